// File: rtl/rotate_sequencer.sv
// Multi-pass 64-bit rotate controller: builds rotates of 0-63 in either direction
// from a 0-31 right-rotate stage by recirculating an accumulator through it.
module rotate_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [63:0] data_in,
    input  logic [5:0]  amt,
    input  logic        dir,
    output logic [63:0] result,
    output logic        result_valid,
    input  logic        result_ready,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P16A = 3'd1,
        P16B = 3'd2,
        PFIN = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [63:0] acc, acc_nxt;
    logic [5:0]  r, r_nxt;
    logic [4:0]  samt;
    logic [63:0] rot_out;

    // Single-pass right rotate by samt (the barrel_rotate_right stage).
    assign rot_out = 64'({acc, acc} >> samt);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        r_nxt     = r;
        samt      = 5'd0;
        unique case (state)
            IDLE: begin
                if (start_valid) begin
                    acc_nxt   = data_in;
                    r_nxt     = dir ? 6'(~amt + 6'd1) : amt;
                    state_nxt = r_nxt[5] ? P16A : PFIN;
                end
            end
            P16A: begin
                samt      = 5'd16;
                acc_nxt   = rot_out;
                state_nxt = P16B;
            end
            P16B: begin
                samt      = 5'd16;
                acc_nxt   = rot_out;
                state_nxt = PFIN;
            end
            PFIN: begin
                // r[4:0] may be 0: an identity pass keeps latency uniform.
                samt      = r[4:0];
                acc_nxt   = rot_out;
                state_nxt = DONE;
            end
            DONE: begin
                if (result_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            r     <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            r     <= r_nxt;
        end
    end

    assign start_ready  = (state == IDLE) && !rst;
    assign result_valid = (state == DONE);
    assign busy         = (state != IDLE);
    assign result       = acc;

endmodule

// File: tb/tb_rotate_sequencer.sv
// Directed vector table plus hand sequences and a random sweep for rotate_sequencer.
module tb_rotate_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [63:0] data_in;
    logic [5:0]  amt;
    logic        dir;
    logic [63:0] result;
    logic        result_valid;
    logic        result_ready;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    rotate_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .data_in      (data_in),
        .amt          (amt),
        .dir          (dir),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [5:0]  amt;
        logic        dir;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_rot(input logic [63:0] x, input logic [5:0] a, input logic d);
        int rr;
        rr = d ? ((64 - int'(a)) % 64) : int'(a);
        return (x >> rr) | (x << (64 - rr));
    endfunction

    function automatic int model_lat(input logic [5:0] a, input logic d);
        int rr;
        rr = d ? ((64 - int'(a)) % 64) : int'(a);
        return (rr >= 32) ? 4 : 2;
    endfunction

    // Caller is positioned 1 time unit after a rising edge.
    task automatic wait_ready(input string name);
        int guard = 0;
        while (!start_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check({name, " start_ready"}, 64'(start_ready), 64'd1);
    endtask

    task automatic accept(input logic [63:0] d, input logic [5:0] a, input logic di);
        start_valid = 1'b1;
        data_in     = d;
        amt         = a;
        dir         = di;
        @(posedge clk); #1;
        start_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!result_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_result();
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
    endtask

    task automatic run_req(input logic [63:0] d, input logic [5:0] a, input logic di,
                           input logic [63:0] exp, input int exp_lat, input int stall,
                           input string name);
        int lat;
        logic [63:0] held;
        wait_ready(name);
        accept(d, a, di);
        wait_done(lat);
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " result"}, result, exp);
        held = result;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            if (!result_valid || result !== held)
                check({name, " stall hold"}, {63'd0, result_valid} ^ result ^ held, 64'd1);
        end
        release_result();
    endtask

    task automatic samt_seq(input logic [63:0] d, input logic [5:0] a, input logic di,
                            input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                            input logic [63:0] exp, input string name);
        wait_ready(name);
        accept(d, a, di);
        check({name, " samt0"}, 64'(dut.samt), 64'(s0));
        @(posedge clk); #1;
        check({name, " samt1"}, 64'(dut.samt), 64'(s1));
        @(posedge clk); #1;
        check({name, " samt2"}, 64'(dut.samt), 64'(s2));
        @(posedge clk); #1;
        check({name, " valid"}, 64'(result_valid), 64'd1);
        check({name, " result"}, result, exp);
        release_result();
    endtask

    initial begin
        int lat;
        logic [63:0] d;
        logic [5:0]  a;
        logic        di;

        vecs[0]  = '{64'h0123456789ABCDEF, 6'd4,  1'b0, 64'hF0123456789ABCDE, 2};
        vecs[1]  = '{64'h0123456789ABCDEF, 6'd40, 1'b0, 64'h6789ABCDEF012345, 4};
        vecs[2]  = '{64'h8000000000000001, 6'd1,  1'b1, 64'h0000000000000003, 4};
        vecs[3]  = '{64'hDEADBEEF00C0FFEE, 6'd0,  1'b1, 64'hDEADBEEF00C0FFEE, 2};
        vecs[4]  = '{64'hDEADBEEF00C0FFEE, 6'd0,  1'b0, 64'hDEADBEEF00C0FFEE, 2};
        vecs[5]  = '{64'h0123456789ABCDEF, 6'd4,  1'b1, 64'h123456789ABCDEF0, 4};
        vecs[6]  = '{64'h0123456789ABCDEF, 6'd32, 1'b0, 64'h89ABCDEF01234567, 4};
        vecs[7]  = '{64'h0123456789ABCDEF, 6'd32, 1'b1, 64'h89ABCDEF01234567, 4};
        vecs[8]  = '{64'h0123456789ABCDEF, 6'd16, 1'b0, 64'hCDEF0123456789AB, 2};
        vecs[9]  = '{64'h0000000000000001, 6'd63, 1'b0, 64'h0000000000000002, 4};
        vecs[10] = '{64'h0000000000000001, 6'd63, 1'b1, 64'h8000000000000000, 2};

        rst          = 1'b1;
        start_valid  = 1'b0;
        data_in      = '0;
        amt          = '0;
        dir          = 1'b0;
        result_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset start_ready", 64'(start_ready), 64'd0);
        check("reset result_valid", 64'(result_valid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset result", result, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post-reset start_ready", 64'(start_ready), 64'd1);

        for (int i = 0; i < 11; i++)
            run_req(vecs[i].data, vecs[i].amt, vecs[i].dir, vecs[i].exp, vecs[i].lat, 0,
                    $sformatf("vec%0d", i));

        samt_seq(64'h0123456789ABCDEF, 6'd40, 1'b0, 5'd16, 5'd16, 5'd8,
                 64'h6789ABCDEF012345, "right40 seq");
        samt_seq(64'h8000000000000001, 6'd1, 1'b1, 5'd16, 5'd16, 5'd31,
                 64'h0000000000000003, "left1 seq");

        // Back-pressure: DONE held with a competing request waiting.
        wait_ready("bp");
        accept(64'h0123456789ABCDEF, 6'd4, 1'b0);
        wait_done(lat);
        start_valid = 1'b1;
        data_in     = 64'h0000000000000001;
        amt         = 6'd1;
        dir         = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("bp hold%0d result", i), result, 64'hF0123456789ABCDE);
            check($sformatf("bp hold%0d valid", i), 64'(result_valid), 64'd1);
            check($sformatf("bp hold%0d start_ready", i), 64'(start_ready), 64'd0);
        end
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        check("bp idle start_ready", 64'(start_ready), 64'd1);
        check("bp idle valid", 64'(result_valid), 64'd0);
        @(posedge clk); #1;
        start_valid = 1'b0;
        check("bp second accepted", 64'(busy), 64'd1);
        lat = 1;
        while (!result_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp second latency", 64'(lat), 64'd2);
        check("bp second result", result, 64'h8000000000000000);
        release_result();

        // Reset while in P16B of a right-50 request.
        wait_ready("rst mid");
        accept(64'h0123456789ABCDEF, 6'd50, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst mid valid", 64'(result_valid), 64'd0);
        check("rst mid busy", 64'(busy), 64'd0);
        check("rst mid acc", dut.acc, 64'd0);
        check("rst mid start_ready", 64'(start_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst mid start_ready after", 64'(start_ready), 64'd1);
        @(posedge clk); #1;
        run_req(64'h1, 6'd1, 1'b0, 64'h8000000000000000, 2, 0, "after rst");

        for (int i = 0; i < 1000; i++) begin
            d  = {$urandom, $urandom};
            a  = 6'($urandom_range(0, 63));
            di = 1'($urandom_range(0, 1));
            run_req(d, a, di, model_rot(d, a, di), model_lat(a, di),
                    $urandom_range(0, 3), $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
